// File: rtl/sample_packer.sv
// Record FIFO plus LSB-first byte serializer feeding the FX2 sample handshake.
// Optional saturating drop counter enabled by defining SAMPLE_PACKER_LOSTCNT_EN.
module sample_packer #(
  parameter int RECORD_BYTES = 6,
  parameter int FIFO_ADDR_W  = 4
) (
  input  logic                      fx2_clk,
  input  logic                      reset,
  input  logic [8*RECORD_BYTES-1:0] record,
  input  logic                      record_valid,
  output logic                      record_drop,
  output logic [FIFO_ADDR_W:0]      fifo_level,
  output logic [7:0]                sample,
  output logic                      sample_rdy,
  input  logic                      sample_ack,
  output logic [15:0]               lost_count
);

  localparam int RW    = 8 * RECORD_BYTES;
  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int IDX_W = $clog2(RECORD_BYTES);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(RECORD_BYTES - 1);
  localparam logic [FIFO_ADDR_W:0] DEPTH_LVL = (FIFO_ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // Handshake: a byte moves on any cycle where sample_rdy and sample_ack are both 1;
  // sample/sample_rdy hold steady while sample_ack is low.
  state_t                 state_q, state_d;
  logic [RW-1:0]          mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_W:0]   count_q;
  logic [RW-1:0]          s_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   full, push, drop, pop, shift, nonempty;

  assign full     = (count_q == DEPTH_LVL);
  assign nonempty = (count_q != '0);
  // A full FIFO drops the record even if a pop frees a slot this cycle.
  assign push     = record_valid && !full;
  assign drop     = record_valid && full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (nonempty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sample_ack) begin
          if (idx_q != LAST_IDX) begin
            shift = 1'b1;
          end else if (nonempty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      record_drop <= 1'b0;
    end else begin
      state_q     <= state_d;
      record_drop <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop) begin
        s_q   <= mem[rd_ptr];
        idx_q <= '0;
      end else if (shift) begin
        s_q   <= s_q >> 8;
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign fifo_level = count_q;
  assign sample_rdy = (state_q == SEND);
  assign sample     = sample_rdy ? s_q[7:0] : 8'h00;

`ifdef SAMPLE_PACKER_LOSTCNT_EN
  logic [15:0] lost_q;
  // Counts alongside the record_drop flop so both become visible together.
  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      lost_q <= '0;
    end else if (drop && lost_q != 16'hFFFF) begin
      lost_q <= lost_q + 16'd1;
    end
  end
  assign lost_count = lost_q;
`else
  assign lost_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: directed scenarios plus random traffic checked every cycle
// against a queue-based model of records and outgoing bytes.
module tb_sample_packer;
  localparam int RB    = 6;
  localparam int AW    = 4;
  localparam int W     = 8 * RB;
  localparam int DEPTH = 1 << AW;

  logic          fx2_clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  record = '0;
  logic          record_valid = 1'b0;
  logic          record_drop;
  logic [AW:0]   fifo_level;
  logic [7:0]    sample;
  logic          sample_rdy;
  logic          sample_ack = 1'b0;
  logic [15:0]   lost_count;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: queued records, remaining bytes of the record on the wire.
  logic [W-1:0]  rec_q[$];
  logic [7:0]    exp_q[$];
  logic          m_drop = 1'b0;
  logic [15:0]   m_lost = 16'h0000;
  int            drop_pulses = 0;

  sample_packer #(.RECORD_BYTES(RB), .FIFO_ADDR_W(AW)) dut (
    .fx2_clk     (fx2_clk),
    .reset       (reset),
    .record      (record),
    .record_valid(record_valid),
    .record_drop (record_drop),
    .fifo_level  (fifo_level),
    .sample      (sample),
    .sample_rdy  (sample_rdy),
    .sample_ack  (sample_ack),
    .lost_count  (lost_count)
  );

  always #5 fx2_clk = ~fx2_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic         full, xfer, do_pop;
    logic [W-1:0] r;
    if (reset) begin
      rec_q.delete();
      exp_q.delete();
      m_drop = 1'b0;
      m_lost = 16'h0000;
      return;
    end
    full   = (rec_q.size() == DEPTH);
    xfer   = (exp_q.size() > 0) && sample_ack;
    do_pop = (rec_q.size() > 0) && ((exp_q.size() == 0) || (xfer && exp_q.size() == 1));
    if (xfer) void'(exp_q.pop_front());
    if (do_pop) begin
      r = rec_q.pop_front();
      for (int i = 0; i < RB; i++) exp_q.push_back(r[8*i +: 8]);
    end
    if (record_valid && !full) rec_q.push_back(record);
    m_drop = record_valid && full;
`ifdef SAMPLE_PACKER_LOSTCNT_EN
    if (m_drop && m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
`endif
  endtask

  task automatic check_outputs();
    chk("sample_rdy", 32'(sample_rdy), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("sample", 32'(sample), 32'(exp_q[0]));
    chk("fifo_level", 32'(fifo_level), 32'(rec_q.size()));
    chk("record_drop", 32'(record_drop), 32'(m_drop));
    chk("lost_count", 32'(lost_count), 32'(m_lost));
    if (record_drop) drop_pulses++;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the next negedge.
  task automatic do_cycle(input logic v, input logic [W-1:0] r, input logic a);
    record_valid = v;
    record       = r;
    sample_ack   = a;
    @(posedge fx2_clk);
    model_step();
    @(negedge fx2_clk);
    check_outputs();
  endtask

  function automatic logic [W-1:0] rand_rec();
    return {16'($urandom), $urandom};
  endfunction

  initial begin
    logic [W-1:0] rec_a;
    rec_a = 48'h060504030201;

    // Clock/reset
    reset = 1'b1;
    do_cycle(1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    reset = 1'b0;
    chk("reset_sample", 32'(sample), 32'h0);
    chk("reset_rdy", 32'(sample_rdy), 32'h0);
    chk("reset_level", 32'(fifo_level), 32'h0);
    chk("reset_lost", 32'(lost_count), 32'h0);

    // Single record, ack high: byte 0 visible two cycles after the strobe.
    do_cycle(1'b1, rec_a, 1'b1);
    chk("lat_n1_rdy", 32'(sample_rdy), 32'h0);
    do_cycle(1'b0, '0, 1'b1);
    chk("lat_n2_rdy", 32'(sample_rdy), 32'h1);
    chk("lat_n2_byte", 32'(sample), 32'h01);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, '0, 1'b1);
    chk("single_done_rdy", 32'(sample_rdy), 32'h0);
    chk("single_done_level", 32'(fifo_level), 32'h0);

    // Ack stall after byte 01 transferred: 02 must hold.
    do_cycle(1'b1, rec_a, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, '0, 1'b0);
    chk("stall_hold_byte", 32'(sample), 32'h02);
    chk("stall_hold_rdy", 32'(sample_rdy), 32'h1);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, '0, 1'b1);

    // Back-to-back records, gapless stream.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, rand_rec(), 1'b1);
    for (int i = 0; i < 22; i++) do_cycle(1'b0, '0, 1'b1);

    // Overflow: 18 strobes with ack low, last one dropped.
    drop_pulses = 0;
    for (int i = 0; i < 18; i++) do_cycle(1'b1, rand_rec(), 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovf_drop_pulses", 32'(drop_pulses), 32'h1);
`ifdef SAMPLE_PACKER_LOSTCNT_EN
    chk("ovf_lost", 32'(lost_count), 32'h1);
`else
    chk("ovf_lost", 32'(lost_count), 32'h0);
`endif
    for (int i = 0; i < 17 * RB + 8; i++) do_cycle(1'b0, '0, 1'b1);
    chk("ovf_drained_level", 32'(fifo_level), 32'h0);

    // Reset mid-record with two records queued.
    do_cycle(1'b1, rand_rec(), 1'b1);
    do_cycle(1'b1, rand_rec(), 1'b1);
    do_cycle(1'b1, rand_rec(), 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    reset = 1'b1;
    do_cycle(1'b0, '0, 1'b1);
    reset = 1'b0;
    chk("midrst_rdy", 32'(sample_rdy), 32'h0);
    chk("midrst_level", 32'(fifo_level), 32'h0);
    chk("midrst_lost", 32'(lost_count), 32'h0);
    for (int i = 0; i < 6; i++) do_cycle(1'b0, '0, 1'b1);
    chk("midrst_quiet", 32'(sample_rdy), 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      do_cycle($urandom_range(0, 9) < 4, rand_rec(), $urandom_range(0, 9) < 7);
    for (int i = 0; i < (DEPTH + 1) * RB + 8; i++) do_cycle(1'b0, '0, 1'b1);
    chk("random_drained", 32'(fifo_level), 32'h0);

`ifdef SAMPLE_PACKER_LOSTCNT_EN
    // Saturation of the drop counter.
    reset = 1'b1;
    do_cycle(1'b0, '0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1'b1, rand_rec(), 1'b0);
    drop_pulses = 0;
    for (int i = 0; i < 65540; i++) do_cycle(1'b1, rand_rec(), 1'b0);
    do_cycle(1'b0, '0, 1'b0);
    chk("sat_lost", 32'(lost_count), 32'hFFFF);
    chk("sat_drop_pulses", 32'(drop_pulses), 32'd65540);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
